// File: rtl/sumador_serial_n.sv
// Bit-serial adder/subtractor: DIGIT bits per clock through a single carry flop,
// with a start/busy/done handshake and registered sum, carry-out and overflow.
`timescale 1ns/1ps

module sumador_serial_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = DIGIT + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("sumador_serial_n: DIGIT must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [DIGIT:0]   sum_d;
    logic             msb_cin_d;
    logic [WIDTH-1:0] res_d;

    // NOTE: every always_comb output is assigned unconditionally, so no latch can be inferred.
    always_comb begin
        sum_d     = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]} + DW'(carry_q);
        // Carry into the digit's top bit, recovered from its sum bit and operand bits.
        msb_cin_d = sum_d[DIGIT-1] ^ opa_q[DIGIT-1] ^ opb_q[DIGIT-1];
        res_d     = (res_q >> DIGIT) | (WIDTH'(sum_d[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= sub ? ~b : b;
                        carry_q <= cin ^ sub;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    opa_q   <= opa_q >> DIGIT;
                    opb_q   <= opb_q >> DIGIT;
                    carry_q <= sum_d[DIGIT];
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        cout_q  <= sum_d[DIGIT];
                        ovf_q   <= msb_cin_d ^ sum_d[DIGIT];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = res_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_sumador_serial_n.sv
// Self-checking bench: four WIDTH=8 instances (DIGIT 1,2,4,8) and one WIDTH=16/DIGIT=4
// instance, checked against an arithmetic reference model plus literal expectations.
`timescale 1ns/1ps

module tb_sumador_serial_n;

    typedef struct packed {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       sb;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_v [5];
    logic        cin_v   [5];
    logic        sub_v   [5];
    logic        busy_v  [5];
    logic        done_v  [5];
    logic        cout_v  [5];
    logic        ovf_v   [5];
    logic [7:0]  a8 [4];
    logic [7:0]  b8 [4];
    logic [7:0]  s8 [4];
    logic [15:0] a16, b16, s16;

    for (genvar g = 0; g < 4; g++) begin : g_w8
        sumador_serial_n #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
            .clk(clk), .rst(rst), .start(start_v[g]), .a(a8[g]), .b(b8[g]),
            .cin(cin_v[g]), .sub(sub_v[g]), .busy(busy_v[g]), .done(done_v[g]),
            .s(s8[g]), .cout(cout_v[g]), .ovf(ovf_v[g])
        );
    end

    sumador_serial_n #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst(rst), .start(start_v[4]), .a(a16), .b(b16),
        .cin(cin_v[4]), .sub(sub_v[4]), .busy(busy_v[4]), .done(done_v[4]),
        .s(s16), .cout(cout_v[4]), .ovf(ovf_v[4])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, no serial structure.
    function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                   input logic c, input logic sb);
        longint mask, half, ua, ub, cl, full, sa, sbv, ss;
        exp_t   e;
        mask = (64'sd1 <<< w) - 1;
        half = 64'sd1 <<< (w - 1);
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        cl   = c ? 64'sd1 : 64'sd0;
        sa   = (ua >= half) ? ua - (mask + 1) : ua;
        sbv  = (ub >= half) ? ub - (mask + 1) : ub;
        if (!sb) begin
            full   = ua + ub + cl;
            e.cout = ((full >>> w) & 1) != 0;
            ss     = sa + sbv + cl;
        end else begin
            full   = ua - ub - cl;
            e.cout = (ua >= ub + cl);
            ss     = sa - sbv - cl;
        end
        e.s   = 16'(full & mask);
        e.ovf = (ss >= half) || (ss < -half);
        return e;
    endfunction

    exp_t        ring [5][4];
    int          wr   [5] = '{default: 0};
    int          rd   [5] = '{default: 0};
    int          ndone[5] = '{default: 0};
    logic [15:0] last_s [5];
    logic        last_c [5];
    logic        last_o [5];

    // Compare process: every done pulse is matched against the oldest pending expectation.
    always @(negedge clk) begin
        logic [15:0] sv;
        exp_t        e;
        for (int i = 0; i < 5; i++) begin
            if (rst) begin
                rd[i] = wr[i];
            end else if (done_v[i]) begin
                if (i < 4) sv = {8'h00, s8[i]};
                else       sv = s16;
                check($sformatf("busy_with_done[%0d]", i), 32'(busy_v[i]), 0);
                if (rd[i] == wr[i]) begin
                    check($sformatf("spurious_done[%0d]", i), 32'(done_v[i]), 0);
                end else begin
                    e = ring[i][rd[i] % 4];
                    rd[i]++;
                    check($sformatf("s[%0d]", i), 32'(sv), 32'(e.s));
                    check($sformatf("cout[%0d]", i), 32'(cout_v[i]), 32'(e.cout));
                    check($sformatf("ovf[%0d]", i), 32'(ovf_v[i]), 32'(e.ovf));
                end
                last_s[i] = sv;
                last_c[i] = cout_v[i];
                last_o[i] = ovf_v[i];
                ndone[i]++;
            end
        end
    end

    function automatic int nbeats(input int i);
        return (i < 4) ? (8 >> i) : 4;
    endfunction

    task automatic set_inputs(input int i, input logic [15:0] av, input logic [15:0] bv,
                              input logic c, input logic sb);
        if (i < 4) begin
            a8[i] = av[7:0];
            b8[i] = bv[7:0];
        end else begin
            a16 = av;
            b16 = bv;
        end
        cin_v[i] = c;
        sub_v[i] = sb;
    endtask

    task automatic push_exp(input int i, input logic [15:0] av, input logic [15:0] bv,
                            input logic c, input logic sb);
        ring[i][wr[i] % 4] = model((i < 4) ? 8 : 16, av, bv, c, sb);
        wr[i]++;
    endtask

    // Present one start pulse; returns #1 after the accepting edge with inputs scrambled.
    task automatic launch(input int i, input logic [15:0] av, input logic [15:0] bv,
                          input logic c, input logic sb);
        @(negedge clk);
        set_inputs(i, av, bv, c, sb);
        start_v[i] = 1'b1;
        push_exp(i, av, bv, c, sb);
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        set_inputs(i, ~av, ~bv, ~c, ~sb);
    endtask

    task automatic do_op(input int i, input logic [15:0] av, input logic [15:0] bv,
                         input logic c, input logic sb);
        int nb;
        bit seen;
        launch(i, av, bv, c, sb);
        nb   = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done_v[i]) begin
                seen = 1'b1;
                break;
            end
            if (busy_v[i]) nb++;
            @(posedge clk);
            #1;
        end
        check($sformatf("done_seen[%0d]", i), 32'(seen), 1);
        check($sformatf("busy_cycles[%0d]", i), nb, nbeats(i));
        @(posedge clk);
        #1;
        check($sformatf("done_one_cycle[%0d]", i), 32'(done_v[i]), 0);
    endtask

    task automatic dir(input int i, input logic [15:0] av, input logic [15:0] bv,
                       input logic c, input logic sb,
                       input logic [15:0] es, input logic ec, input logic eo);
        do_op(i, av, bv, c, sb);
        check($sformatf("lit_s[%0d]", i), 32'(last_s[i]), 32'(es));
        check($sformatf("lit_cout[%0d]", i), 32'(last_c[i]), 32'(ec));
        check($sformatf("lit_ovf[%0d]", i), 32'(last_o[i]), 32'(eo));
    endtask

    vec_t vt [6] = '{
        '{8'h16, 8'h02, 1'b0, 1'b0, 8'h18, 1'b0, 1'b0},
        '{8'h8F, 8'hA8, 1'b0, 1'b0, 8'h37, 1'b1, 1'b1},
        '{8'h40, 8'h41, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1},
        '{8'h44, 8'h07, 1'b0, 1'b1, 8'h3D, 1'b1, 1'b0},
        '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0},
        '{8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0}
    };

    logic [7:0] hold_a [3] = '{8'h01, 8'h80, 8'h7F};
    logic [7:0] hold_b [3] = '{8'h02, 8'h01, 8'h7F};
    logic       hold_c [3] = '{1'b0, 1'b1, 1'b1};
    logic       hold_s [3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        int n;
        int d0;
        bit seen;
        for (int i = 0; i < 5; i++) begin
            start_v[i] = 1'b0;
            set_inputs(i, 16'h0, 16'h0, 1'b0, 1'b0);
        end

        // Reset state
        rst = 1'b1;
        #12;
        for (int i = 0; i < 5; i += 4) begin
            check($sformatf("rst_busy[%0d]", i), 32'(busy_v[i]), 0);
            check($sformatf("rst_done[%0d]", i), 32'(done_v[i]), 0);
            check($sformatf("rst_cout[%0d]", i), 32'(cout_v[i]), 0);
            check($sformatf("rst_ovf[%0d]", i), 32'(ovf_v[i]), 0);
        end
        check("rst_s8", 32'(s8[0]), 0);
        check("rst_s16", 32'(s16), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors on every WIDTH=8 digit size
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 6; k++)
                dir(i, {8'h00, vt[k].a}, {8'h00, vt[k].b}, vt[k].c, vt[k].sb,
                    {8'h00, vt[k].s}, vt[k].co, vt[k].ov);

        dir(4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        dir(4, 16'h1234, 16'h4321, 1'b1, 1'b1, 16'hCF12, 1'b0, 1'b0);

        // start pulsed mid-RUN must be ignored
        d0 = ndone[0];
        launch(0, 16'h0022, 16'h0011, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        start_v[0] = 1'b1;
        set_inputs(0, 16'h00FF, 16'h00FF, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrun_done_count", ndone[0] - d0, 1);
        check("midrun_s", 32'(last_s[0]), 32'h33);
        check("midrun_busy_after", 32'(busy_v[0]), 0);

        // start held high: one done every N+1 cycles, operands resampled each time
        @(negedge clk);
        set_inputs(0, {8'h00, hold_a[0]}, {8'h00, hold_b[0]}, hold_c[0], hold_s[0]);
        push_exp(0, {8'h00, hold_a[0]}, {8'h00, hold_b[0]}, hold_c[0], hold_s[0]);
        start_v[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            n    = 0;
            seen = 1'b0;
            for (int k = 0; k < 30; k++) begin
                @(posedge clk);
                #1;
                n++;
                if (done_v[0]) begin
                    seen = 1'b1;
                    break;
                end
            end
            check($sformatf("held_done_seen[%0d]", j), 32'(seen), 1);
            check($sformatf("held_interval[%0d]", j), n, 9);
            if (j < 2) begin
                set_inputs(0, {8'h00, hold_a[j+1]}, {8'h00, hold_b[j+1]}, hold_c[j+1], hold_s[j+1]);
                push_exp(0, {8'h00, hold_a[j+1]}, {8'h00, hold_b[j+1]}, hold_c[j+1], hold_s[j+1]);
            end else begin
                start_v[0] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("held_idle_busy", 32'(busy_v[0]), 0);
        check("held_last_s", 32'(last_s[0]), 32'hFF);

        // Reset in the middle of RUN aborts with outputs cleared and no done
        d0 = ndone[0];
        launch(0, 16'h0055, 16'h000A, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy_v[0]), 0);
        check("abort_done", 32'(done_v[0]), 0);
        check("abort_s", 32'(s8[0]), 0);
        check("abort_cout", 32'(cout_v[0]), 0);
        check("abort_ovf", 32'(ovf_v[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", ndone[0] - d0, 0);
        dir(0, 16'h0009, 16'h0028, 1'b0, 1'b0, 16'h0031, 1'b0, 1'b0);

        // Random operands for every digit size, checked by the model
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 1000; k++)
                do_op(i, 16'($urandom_range(255)), 16'($urandom_range(255)),
                      1'($urandom_range(1)), 1'($urandom_range(1)));
        for (int k = 0; k < 200; k++)
            do_op(4, 16'($urandom), 16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
